// File: rtl/c_pack.sv
// Packs a stream of mixed 16-bit and 32-bit instructions into aligned 32-bit words.
// Supports flush (pad the pending half with c.nop) and redirect (restart at a new address).
module c_pack #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inst_in,
  input  logic        inst_valid_i,
  output logic        inst_ready_o,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  output logic        cmd_done_o,
  output logic [31:0] pc_out,
  output logic        pc_misaligned_o,
  output logic [31:0] word_o,
  output logic [31:0] word_addr_o,
  output logic        word_valid_o,
  input  logic        word_ready_i
);

  localparam logic [31:0] BASE_ADDR = {RESET_ADDR[31:2], 2'b00};
  localparam logic [15:0] C_NOP     = 16'h0001;

  logic [31:0] wa_r;
  logic [15:0] hq_r;
  logic        hv_r;
  logic [31:0] word_r;
  logic [31:0] word_addr_r;
  logic        word_valid_r;
  logic        cmd_done_r;

  logic        slot_free_s;
  logic        take_redirect_s;
  logic        take_flush_s;
  logic        take_inst_s;
  logic        inst_is_32_s;
  logic [31:0] wa_next_s;
  logic [15:0] hq_next_s;
  logic        hv_next_s;
  logic        emit_s;
  logic [31:0] emit_word_s;
  logic        unused_addr_bit_s;

  assign unused_addr_bit_s = redirect_addr_i[0];

  // A command is not retaken in the cycle its done pulse is visible.
  assign slot_free_s     = !word_valid_r || word_ready_i;
  assign take_redirect_s = redirect_i && slot_free_s && !cmd_done_r;
  assign take_flush_s    = flush_i && !redirect_i && slot_free_s && !cmd_done_r;
  assign inst_ready_o    = slot_free_s && !flush_i && !redirect_i;
  assign take_inst_s     = inst_valid_i && inst_ready_o;
  assign inst_is_32_s    = (inst_in[1:0] == 2'b11);

  assign pc_out          = wa_r + (hv_r ? 32'd2 : 32'd0);
  assign pc_misaligned_o = hv_r;
  assign word_o          = word_r;
  assign word_addr_o     = word_addr_r;
  assign word_valid_o    = word_valid_r;
  assign cmd_done_o      = cmd_done_r;

  // Next packing state and the word to emit, commands first.
  always_comb begin
    wa_next_s   = wa_r;
    hq_next_s   = hq_r;
    hv_next_s   = hv_r;
    emit_s      = 1'b0;
    emit_word_s = 32'h0000_0000;
    if (take_redirect_s) begin
      emit_s      = hv_r;
      emit_word_s = {C_NOP, hq_r};
      wa_next_s   = {redirect_addr_i[31:2], 2'b00};
      if (redirect_addr_i[1]) begin
        hq_next_s = C_NOP;
        hv_next_s = 1'b1;
      end else begin
        hv_next_s = 1'b0;
      end
    end else if (take_flush_s) begin
      if (hv_r) begin
        emit_s      = 1'b1;
        emit_word_s = {C_NOP, hq_r};
        wa_next_s   = wa_r + 32'd4;
        hv_next_s   = 1'b0;
      end else begin
        emit_s = 1'b0;
      end
    end else if (take_inst_s) begin
      case ({hv_r, inst_is_32_s})
        2'b00: begin
          hq_next_s = inst_in[15:0];
          hv_next_s = 1'b1;
        end
        2'b01: begin
          emit_s      = 1'b1;
          emit_word_s = inst_in;
          wa_next_s   = wa_r + 32'd4;
        end
        2'b10: begin
          emit_s      = 1'b1;
          emit_word_s = {inst_in[15:0], hq_r};
          wa_next_s   = wa_r + 32'd4;
          hv_next_s   = 1'b0;
        end
        2'b11: begin
          emit_s      = 1'b1;
          emit_word_s = {inst_in[15:0], hq_r};
          wa_next_s   = wa_r + 32'd4;
          hq_next_s   = inst_in[31:16];
        end
        default: begin
          emit_s = 1'b0;
        end
      endcase
    end else begin
      emit_s = 1'b0;
    end
  end

  // Packing state, output register and command acknowledge.
  always_ff @(posedge clk) begin
    if (reset) begin
      wa_r         <= BASE_ADDR;
      hq_r         <= 16'h0000;
      hv_r         <= 1'b0;
      word_r       <= 32'h0000_0000;
      word_addr_r  <= BASE_ADDR;
      word_valid_r <= 1'b0;
      cmd_done_r   <= 1'b0;
    end else begin
      wa_r       <= wa_next_s;
      hq_r       <= hq_next_s;
      hv_r       <= hv_next_s;
      cmd_done_r <= take_redirect_s || take_flush_s;
      if (emit_s) begin
        word_r       <= emit_word_s;
        word_addr_r  <= wa_r;
        word_valid_r <= 1'b1;
      end else if (word_ready_i) begin
        word_valid_r <= 1'b0;
      end else begin
        word_valid_r <= word_valid_r;
      end
    end
  end

endmodule

// File: tb/tb_c_pack.sv
// Directed self-checking bench for c_pack.
module tb_c_pack;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inst_in;
  logic        inst_valid_i;
  logic        inst_ready_o;
  logic        flush_i;
  logic        redirect_i;
  logic [31:0] redirect_addr_i;
  logic        cmd_done_o;
  logic [31:0] pc_out;
  logic        pc_misaligned_o;
  logic [31:0] word_o;
  logic [31:0] word_addr_o;
  logic        word_valid_o;
  logic        word_ready_i;

  int n_cmp = 0;
  int n_bad = 0;

  c_pack dut (
    .clk(clk), .reset(reset), .inst_in(inst_in), .inst_valid_i(inst_valid_i),
    .inst_ready_o(inst_ready_o), .flush_i(flush_i), .redirect_i(redirect_i),
    .redirect_addr_i(redirect_addr_i), .cmd_done_o(cmd_done_o), .pc_out(pc_out),
    .pc_misaligned_o(pc_misaligned_o), .word_o(word_o), .word_addr_o(word_addr_o),
    .word_valid_o(word_valid_o), .word_ready_i(word_ready_i)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] inst);
    inst_in      = inst;
    inst_valid_i = 1'b1;
    step();
    inst_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; inst_in = 32'h0; inst_valid_i = 1'b0; flush_i = 1'b0;
    redirect_i = 1'b0; redirect_addr_i = 32'h0; word_ready_i = 1'b1;
    step(); step();
    reset = 1'b0;
    #1;
    n_cmp++; if (word_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_valid got=%0b exp=0", word_valid_o); end
    n_cmp++; if (word_o !== 32'h0) begin n_bad++; $display("FAIL rst_word got=%h exp=0", word_o); end
    n_cmp++; if (word_addr_o !== 32'h0) begin n_bad++; $display("FAIL rst_addr got=%h exp=0", word_addr_o); end
    n_cmp++; if (pc_out !== 32'h0 || pc_misaligned_o !== 1'b0) begin n_bad++; $display("FAIL rst_pc got=%h/%0b exp=0/0", pc_out, pc_misaligned_o); end
    n_cmp++; if (cmd_done_o !== 1'b0) begin n_bad++; $display("FAIL rst_done got=%0b exp=0", cmd_done_o); end
    n_cmp++; if (inst_ready_o !== 1'b1) begin n_bad++; $display("FAIL rst_ready got=%0b exp=1", inst_ready_o); end
  endtask

  task automatic test_packing();
    push(32'h0000_c104);
    n_cmp++; if (word_valid_o !== 1'b0) begin n_bad++; $display("FAIL pk1_valid got=%0b exp=0", word_valid_o); end
    n_cmp++; if (pc_out !== 32'h2 || pc_misaligned_o !== 1'b1) begin n_bad++; $display("FAIL pk1_pc got=%h/%0b exp=2/1", pc_out, pc_misaligned_o); end
    push(32'h0040_006f);
    n_cmp++; if (word_valid_o !== 1'b1 || word_o !== 32'h006f_c104 || word_addr_o !== 32'h0) begin n_bad++; $display("FAIL pk2_word got=%0b %h@%h exp=1 006fc104@0", word_valid_o, word_o, word_addr_o); end
    n_cmp++; if (pc_out !== 32'h6) begin n_bad++; $display("FAIL pk2_pc got=%h exp=6", pc_out); end
    push(32'h0000_4104);
    n_cmp++; if (word_valid_o !== 1'b1 || word_o !== 32'h4104_0040 || word_addr_o !== 32'h4) begin n_bad++; $display("FAIL pk3_word got=%0b %h@%h exp=1 41040040@4", word_valid_o, word_o, word_addr_o); end
    n_cmp++; if (pc_out !== 32'h8 || pc_misaligned_o !== 1'b0) begin n_bad++; $display("FAIL pk3_pc got=%h/%0b exp=8/0", pc_out, pc_misaligned_o); end
    step();
    n_cmp++; if (word_valid_o !== 1'b0) begin n_bad++; $display("FAIL pk_drain got=%0b exp=0", word_valid_o); end
  endtask

  task automatic test_backpressure();
    word_ready_i = 1'b0;
    push(32'h00a0_0093);
    n_cmp++; if (word_valid_o !== 1'b1 || word_o !== 32'h00a0_0093 || word_addr_o !== 32'h8) begin n_bad++; $display("FAIL bp_word got=%0b %h@%h exp=1 00a00093@8", word_valid_o, word_o, word_addr_o); end
    inst_in = 32'h00b0_0113; inst_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (inst_ready_o !== 1'b0) begin n_bad++; $display("FAIL bp_ready[%0d] got=%0b exp=0", i, inst_ready_o); end
      step();
      n_cmp++; if (word_valid_o !== 1'b1 || word_o !== 32'h00a0_0093 || word_addr_o !== 32'h8) begin n_bad++; $display("FAIL bp_hold[%0d] got=%0b %h@%h exp=1 00a00093@8", i, word_valid_o, word_o, word_addr_o); end
    end
    word_ready_i = 1'b1;
    #1;
    n_cmp++; if (inst_ready_o !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready got=%0b exp=1", inst_ready_o); end
    step();
    inst_valid_i = 1'b0;
    n_cmp++; if (word_valid_o !== 1'b1 || word_o !== 32'h00b0_0113 || word_addr_o !== 32'hc) begin n_bad++; $display("FAIL bp_next got=%0b %h@%h exp=1 00b00113@c", word_valid_o, word_o, word_addr_o); end
    step();
    n_cmp++; if (word_valid_o !== 1'b0 || pc_out !== 32'h10) begin n_bad++; $display("FAIL bp_once got=%0b pc=%h exp=0 pc=10", word_valid_o, pc_out); end
  endtask

  task automatic test_flush();
    push(32'h0000_4501);
    n_cmp++; if (pc_out !== 32'h12 || pc_misaligned_o !== 1'b1) begin n_bad++; $display("FAIL fl_pre_pc got=%h/%0b exp=12/1", pc_out, pc_misaligned_o); end
    flush_i = 1'b1;
    #1;
    n_cmp++; if (inst_ready_o !== 1'b0) begin n_bad++; $display("FAIL fl_ready got=%0b exp=0", inst_ready_o); end
    step();
    flush_i = 1'b0;
    n_cmp++; if (word_valid_o !== 1'b1 || word_o !== 32'h0001_4501 || word_addr_o !== 32'h10) begin n_bad++; $display("FAIL fl_word got=%0b %h@%h exp=1 00014501@10", word_valid_o, word_o, word_addr_o); end
    n_cmp++; if (cmd_done_o !== 1'b1 || pc_out !== 32'h14 || pc_misaligned_o !== 1'b0) begin n_bad++; $display("FAIL fl_done got=%0b pc=%h/%0b exp=1 14/0", cmd_done_o, pc_out, pc_misaligned_o); end
    step();
    n_cmp++; if (cmd_done_o !== 1'b0 || word_valid_o !== 1'b0) begin n_bad++; $display("FAIL fl_pulse got=%0b/%0b exp=0/0", cmd_done_o, word_valid_o); end
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    n_cmp++; if (cmd_done_o !== 1'b1 || word_valid_o !== 1'b0 || pc_out !== 32'h14) begin n_bad++; $display("FAIL fl_empty got=%0b/%0b pc=%h exp=1/0 14", cmd_done_o, word_valid_o, pc_out); end
    step();
  endtask

  task automatic test_redirect();
    push(32'h0000_0001);
    redirect_i = 1'b1; redirect_addr_i = 32'h100;
    step();
    redirect_i = 1'b0;
    n_cmp++; if (word_valid_o !== 1'b1 || word_o !== 32'h0001_0001 || word_addr_o !== 32'h14) begin n_bad++; $display("FAIL rd_pad got=%0b %h@%h exp=1 00010001@14", word_valid_o, word_o, word_addr_o); end
    n_cmp++; if (cmd_done_o !== 1'b1 || pc_out !== 32'h100 || pc_misaligned_o !== 1'b0) begin n_bad++; $display("FAIL rd_pc got=%0b %h/%0b exp=1 100/0", cmd_done_o, pc_out, pc_misaligned_o); end
    step();
    redirect_i = 1'b1; redirect_addr_i = 32'h203;
    step();
    redirect_i = 1'b0;
    n_cmp++; if (cmd_done_o !== 1'b1 || word_valid_o !== 1'b0 || pc_out !== 32'h202 || pc_misaligned_o !== 1'b1) begin n_bad++; $display("FAIL rd_half got=%0b/%0b %h/%0b exp=1/0 202/1", cmd_done_o, word_valid_o, pc_out, pc_misaligned_o); end
    step();
    push(32'h00a0_0093);
    n_cmp++; if (word_valid_o !== 1'b1 || word_o !== 32'h0093_0001 || word_addr_o !== 32'h200) begin n_bad++; $display("FAIL rd_first got=%0b %h@%h exp=1 00930001@200", word_valid_o, word_o, word_addr_o); end
    n_cmp++; if (pc_out !== 32'h206) begin n_bad++; $display("FAIL rd_first_pc got=%h exp=206", pc_out); end
  endtask

  task automatic test_priority();
    flush_i = 1'b1; redirect_i = 1'b1; redirect_addr_i = 32'h300;
    step();
    redirect_i = 1'b0;
    n_cmp++; if (cmd_done_o !== 1'b1 || word_o !== 32'h0001_00a0 || word_addr_o !== 32'h204 || pc_out !== 32'h300) begin n_bad++; $display("FAIL pr_redirect got=%0b %h@%h pc=%h exp=1 000100a0@204 pc=300", cmd_done_o, word_o, word_addr_o, pc_out); end
    step();
    n_cmp++; if (cmd_done_o !== 1'b0) begin n_bad++; $display("FAIL pr_gap got=%0b exp=0", cmd_done_o); end
    step();
    flush_i = 1'b0;
    n_cmp++; if (cmd_done_o !== 1'b1 || word_valid_o !== 1'b0 || pc_out !== 32'h300) begin n_bad++; $display("FAIL pr_flush got=%0b/%0b pc=%h exp=1/0 300", cmd_done_o, word_valid_o, pc_out); end
    step();
  endtask

  task automatic test_wrap();
    redirect_i = 1'b1; redirect_addr_i = 32'hffff_fffc;
    step();
    redirect_i = 1'b0;
    step();
    n_cmp++; if (pc_out !== 32'hffff_fffc) begin n_bad++; $display("FAIL wr_pre got=%h exp=fffffffc", pc_out); end
    push(32'h0000_0013);
    n_cmp++; if (word_valid_o !== 1'b1 || word_o !== 32'h0000_0013 || word_addr_o !== 32'hffff_fffc) begin n_bad++; $display("FAIL wr_word got=%0b %h@%h exp=1 00000013@fffffffc", word_valid_o, word_o, word_addr_o); end
    n_cmp++; if (pc_out !== 32'h0) begin n_bad++; $display("FAIL wr_pc got=%h exp=0", pc_out); end
    step();
  endtask

  task automatic test_reset_mid();
    push(32'h0000_0002);
    word_ready_i = 1'b0;
    push(32'h0010_0073);
    n_cmp++; if (word_valid_o !== 1'b1 || word_o !== 32'h0073_0002 || pc_out !== 32'h6) begin n_bad++; $display("FAIL rm_pre got=%0b %h pc=%h exp=1 00730002 pc=6", word_valid_o, word_o, pc_out); end
    reset = 1'b1; inst_in = 32'h0000_0013; inst_valid_i = 1'b1; flush_i = 1'b1;
    step();
    reset = 1'b0; inst_valid_i = 1'b0; flush_i = 1'b0; word_ready_i = 1'b1;
    n_cmp++; if (word_valid_o !== 1'b0 || word_o !== 32'h0 || word_addr_o !== 32'h0) begin n_bad++; $display("FAIL rm_word got=%0b %h@%h exp=0 0@0", word_valid_o, word_o, word_addr_o); end
    n_cmp++; if (pc_out !== 32'h0 || pc_misaligned_o !== 1'b0 || cmd_done_o !== 1'b0) begin n_bad++; $display("FAIL rm_state got=%h/%0b/%0b exp=0/0/0", pc_out, pc_misaligned_o, cmd_done_o); end
    push(32'h0000_c104);
    push(32'h0000_4104);
    n_cmp++; if (word_valid_o !== 1'b1 || word_o !== 32'h4104_c104 || word_addr_o !== 32'h0) begin n_bad++; $display("FAIL rm_lost got=%0b %h@%h exp=1 4104c104@0", word_valid_o, word_o, word_addr_o); end
  endtask

  initial begin
    test_reset();
    test_packing();
    test_backpressure();
    test_flush();
    test_redirect();
    test_priority();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/c_pack.md
# c_pack

Instruction-stream packer for the compressed-extension datapath. Accepts a stream of mixed 16-bit (RVC) and 32-bit instructions and packs them into aligned 32-bit words with word addresses, for instruction-memory images and fetch-buffer refill. It is the write-side counterpart of the fetch realigner: any instruction may start on a halfword boundary and may straddle two words. It also supports flush (pad and drain) and redirect (start a new packing address).

## Interface
Parameters:
- RESET_ADDR, 32'h0000_0000, starting byte address after reset; bits [1:0] are ignored.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- inst_in  in  32  instruction; 16-bit when inst_in[1:0] != 2'b11, using only [15:0].
- inst_valid_i  in  1  inst_in is valid.
- inst_ready_o  out  1  instruction accepted this cycle when high together with inst_valid_i.
- flush_i  in  1  flush request; level, held until cmd_done_o.
- redirect_i  in  1  redirect request; level, held until cmd_done_o.
- redirect_addr_i  in  32  new byte address; bit 0 is ignored.
- cmd_done_o  out  1  one-cycle pulse, the cycle after a command is taken.
- pc_out  out  32  byte address the presented instruction will occupy.
- pc_misaligned_o  out  1  pc_out[1]; the next instruction starts on a halfword.
- word_o  out  32  packed word.
- word_addr_o  out  32  byte address of word_o; always has [1:0]=0.
- word_valid_o  out  1  word_o is valid.
- word_ready_i  in  1  consumer accepts word_o.

## Operation
- State:
  - wa: next word byte address.
  - hq[15:0]: pending lower half of the next word.
  - hv: hq is valid.
  - One-entry output register: word_o, word_addr_o, word_valid_o.
- pc_out = wa + (hv ? 2 : 0); pc_misaligned_o = hv. Both are combinational from state.
- Slot free: slot_free = !word_valid_o || word_ready_i.
- Instruction ready: inst_ready_o = slot_free && !flush_i && !redirect_i. Commands have priority over instructions.
- Accepting an instruction:
  - !hv, 16-bit: hq <= inst[15:0]; hv <= 1; no word emitted.
  - !hv, 32-bit: emit inst_in at wa; wa += 4.
  - hv, 16-bit: emit {inst[15:0], hq} at wa; wa += 4; hv <= 0.
  - hv, 32-bit: emit {inst[15:0], hq} at wa; wa += 4; hq <= inst[31:16]; hv stays 1.
- Flush is taken when flush_i && !redirect_i && slot_free:
  - If hv: emit {16'h0001, hq} at wa. 16'h0001 is the c.nop pad. Then wa += 4 and hv <= 0.
  - If !hv: no word is emitted; state is unchanged.
- Redirect is taken when redirect_i && slot_free. It has priority over a simultaneous flush, which remains pending.
  - If hv: the pending half is padded and emitted exactly as in flush.
  - Then wa <= {redirect_addr_i[31:2], 2'b00}.
  - If redirect_addr_i[1]: hq <= 16'h0001 and hv <= 1, so the first instruction lands at the halfword. Otherwise hv <= 0.
- Emit: word_o, word_addr_o and word_valid_o are loaded on the clock edge.
- Output register behaviour:
  - If no new word is loaded and word_ready_i is high, word_valid_o <= 0.
  - While word_valid_o && !word_ready_i, word_o and word_addr_o hold stable.
- wa wraps modulo 2^32: 32'hFFFF_FFFC + 4 = 0.

## Timing
- Reset values (applied on the clock edge with reset high):
  - word_valid_o=0, word_o=0, word_addr_o=RESET_ADDR&~3.
  - wa=RESET_ADDR&~3, hv=0, hq=0.
  - cmd_done_o=0, pc_out=RESET_ADDR&~3, pc_misaligned_o=0.
- Reset overrides any simultaneous instruction, command or handshake. A command in progress is discarded and no cmd_done_o is issued.
- Latency: a word is visible one cycle after the accepting edge. cmd_done_o pulses one cycle after the taking edge, whether or not a word was emitted.
- Throughput: one instruction per cycle while the consumer keeps word_ready_i high.
- Back-to-back emits are permitted: a new word loads on the same edge the old one is consumed.
- Commands are never taken in consecutive cycles without the requester seeing cmd_done_o. After cmd_done_o the requester drops the request. If it is still high the following cycle, it is treated as a new command.

## Test plan
- Packing across words: after reset, push 16'hc104, then 32'h0040006f, then 16'h4104, with word_ready_i=1.
  - First push: no word; pc_out goes 0 -> 2 and pc_misaligned_o=1.
  - Second push: word 32'h006fc104 @0.
  - Third push: word 32'h41040040 @4; pc_misaligned_o=0 and pc_out=8.
- Backpressure: hold word_ready_i=0 with a word pending.
  - inst_ready_o=0 and word_o stays stable for 5 cycles.
  - Release word_ready_i: exactly one handshake, and the next instruction is accepted in the same cycle.
- Flush:
  - With hv=1 and hq=16'h4501: flush emits 32'h00014501 @wa, cmd_done_o pulses, hv=0.
  - Flush with hv=0: no word, cmd_done_o still pulses.
- Redirect and priority:
  - Redirect to 32'h100 with hv=1: pad word emitted, then wa=32'h100 and pc_out=32'h100.
  - Redirect to 32'h202: pc_out=32'h202; the next 32-bit instruction 32'h00a00093 emits 32'h00930001 @32'h200.
  - flush_i and redirect_i high together: the redirect is taken first.
- Wrap-around and reset:
  - With wa=32'hFFFFFFFC, a 32-bit push emits @32'hFFFFFFFC and then pc_out=0.
  - Reset asserted with hv=1 and word_valid_o=1: all outputs return to reset values next cycle and the pending half is lost.
